// File: rtl/sng_pkg.sv
// rtl/sng_pkg.sv - shared types, LFSR tap table and stream length helper for the stochastic number generator
package sng_pkg;

    typedef enum logic {IDLE, RUN} sng_state_e;

    // Maximal-length Fibonacci feedback masks, bit k set means state[k] feeds the XOR
    localparam logic [11:0] LFSR_TAPS [4:12] = '{
        12'h00C, 12'h014, 12'h030, 12'h060, 12'h0B8,
        12'h110, 12'h240, 12'h500, 12'h829
    };

    function automatic int stream_len(input int width);
        return (1 << width) - 1;
    endfunction

endpackage

// File: rtl/sng_lfsr.sv
// rtl/sng_lfsr.sv - Fibonacci maximal-length LFSR with load-to-seed priority over step
module sng_lfsr
    import sng_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int SEED  = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             step,
    output logic [WIDTH-1:0] state
);

    localparam logic [WIDTH-1:0] TAPS   = LFSR_TAPS[WIDTH][WIDTH-1:0];
    localparam logic [WIDTH-1:0] SEED_V = WIDTH'(SEED);

    logic feedback;

    assign feedback = ^(state & TAPS);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= SEED_V;
        end else if (load) begin
            state <= SEED_V;
        end else if (step) begin
            state <= {state[WIDTH-2:0], feedback};
        end
    end

endmodule

// File: rtl/sng_bank8.sv
// rtl/sng_bank8.sv - eight-lane unipolar stochastic number generator; SNG_LANE_ROTATE_EN enables per-lane LFSR rotation
module sng_bank8
    import sng_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int SEED  = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [8*WIDTH-1:0] in_val,
    input  logic               out_ready,
    output logic               out_valid,
    output logic [7:0]         out_bits,
    output logic               out_last
);

    localparam logic [WIDTH-1:0] CNT_LAST = WIDTH'(stream_len(WIDTH) - 1);

    sng_state_e       state, state_nxt;
    logic [WIDTH-1:0] cnt;
    logic [WIDTH-1:0] val_q [8];
    logic [WIDTH-1:0] r_lane [8];
    logic [WIDTH-1:0] lfsr_state;
    logic             is_last;
    logic             beat;
    logic             accept;

    assign is_last = (state == RUN) && (cnt == CNT_LAST);
    assign beat    = (state == RUN) && out_ready;
    assign accept  = in_valid && in_ready;

    sng_lfsr #(.WIDTH(WIDTH), .SEED(SEED)) u_lfsr (
        .clk   (clk),
        .rst   (rst),
        .load  (accept),
        .step  (beat),
        .state (lfsr_state)
    );

    // Every lane sees a permutation of 1..L, so ones counts stay exact in both modes
    for (genvar i = 0; i < 8; i++) begin : g_lane
`ifdef SNG_LANE_ROTATE_EN
        localparam int K = i % WIDTH;
        if (K == 0) begin : g_norot
            assign r_lane[i] = lfsr_state;
        end else begin : g_rot
            assign r_lane[i] = {lfsr_state[WIDTH-1-K:0], lfsr_state[WIDTH-1:WIDTH-K]};
        end
`else
        assign r_lane[i] = lfsr_state;
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (in_valid) state_nxt = RUN;
            RUN:  if (beat && is_last && !in_valid) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        out_valid = (state == RUN);
        out_last  = is_last;
        in_ready  = (state == IDLE) || (is_last && out_ready);
        out_bits  = '0;
        for (int i = 0; i < 8; i++) begin
            out_bits[i] = (state == RUN) && (r_lane[i] <= val_q[i]);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (accept || (beat && is_last)) begin
            cnt <= '0;
        end else if (beat) begin
            cnt <= cnt + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 8; i++) val_q[i] <= '0;
        end else if (accept) begin
            for (int i = 0; i < 8; i++) val_q[i] <= in_val[i*WIDTH +: WIDTH];
        end
    end

endmodule

// File: tb/tb_sng_bank8.sv
// tb/tb_sng_bank8.sv - randomized self-checking bench for sng_bank8 at WIDTH=4
module tb_sng_bank8;

    localparam int W    = 4;
    localparam int L    = 15;
    localparam int SEED = 1;

    logic           clk = 1'b0;
    logic           rst;
    logic           in_valid;
    logic           in_ready;
    logic [8*W-1:0] in_val;
    logic           out_ready;
    logic           out_valid;
    logic [7:0]     out_bits;
    logic           out_last;

    int checks = 0;
    int errors = 0;

    int       cnt_ones [8];
    int       beats, gaps, last_bad, ready_bad, frozen_bad, diff_cycles;
    logic [7:0] first_bits;
    int       vals [8];

    sng_bank8 #(.WIDTH(W), .SEED(SEED)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_val    (in_val),
        .out_ready (out_ready),
        .out_valid (out_valid),
        .out_bits  (out_bits),
        .out_last  (out_last)
    );

    always #5 clk = ~clk;

    function automatic logic [3:0] rotl4(input logic [3:0] s, input int k);
        logic [7:0] t;
        t = {s, s} << k;
        return t[7:4];
    endfunction

    // First beat of every stream sees the seed, so each lane bit is seed-rotation <= value
    function automatic logic [7:0] model_first_bits();
        logic [7:0] b;
        logic [3:0] r;
        for (int i = 0; i < 8; i++) begin
`ifdef SNG_LANE_ROTATE_EN
            r = rotl4(4'(SEED), i % W);
`else
            r = 4'(SEED);
`endif
            b[i] = (int'(r) <= vals[i]);
        end
        return b;
    endfunction

    task automatic load_set();
        in_valid = 1'b1;
        for (int i = 0; i < 8; i++) in_val[i*W +: W] = 4'(vals[i]);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic random_vals();
        for (int i = 0; i < 8; i++) vals[i] = $urandom_range(0, 15);
    endtask

    task automatic collect(input bit rand_ready);
        logic       prev_stall, took;
        logic [7:0] prev_bits;
        logic       prev_last;
        int         cycles;
        for (int i = 0; i < 8; i++) cnt_ones[i] = 0;
        beats = 0; gaps = 0; last_bad = 0; ready_bad = 0; frozen_bad = 0; diff_cycles = 0;
        first_bits = '0; prev_stall = 1'b0; prev_bits = '0; prev_last = 1'b0; cycles = 0;
        while (beats < L && cycles < 300) begin
            out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            #1;
            if (!out_valid) begin
                gaps++;
            end else begin
                if (prev_stall && (out_bits !== prev_bits || out_last !== prev_last)) frozen_bad++;
                if (in_ready !== ((beats == L-1) && out_ready)) ready_bad++;
                if (out_ready) begin
                    if (beats == 0) first_bits = out_bits;
                    for (int i = 0; i < 8; i++) cnt_ones[i] += int'(out_bits[i]);
                    if (out_bits != 8'h00 && out_bits != 8'hFF) diff_cycles++;
                    if (out_last !== (beats == L-1)) last_bad++;
                    beats++;
                    prev_stall = 1'b0;
                end else begin
                    prev_stall = 1'b1;
                    prev_bits  = out_bits;
                    prev_last  = out_last;
                end
            end
            took = in_valid && in_ready;
            @(negedge clk);
            cycles++;
            if (took) in_valid = 1'b0;
        end
        out_ready = 1'b1;
    endtask

    task automatic check_stream(input string name);
        logic [7:0] exp_first;
        exp_first = model_first_bits();
        checks++;
        if (beats !== L) begin errors++; $display("FAIL %s beats got %0d want %0d", name, beats, L); end
        checks++;
        if (gaps !== 0) begin errors++; $display("FAIL %s gaps got %0d want 0", name, gaps); end
        checks++;
        if (last_bad !== 0) begin errors++; $display("FAIL %s out_last misplaced %0d times", name, last_bad); end
        checks++;
        if (ready_bad !== 0) begin errors++; $display("FAIL %s in_ready wrong %0d times", name, ready_bad); end
        checks++;
        if (frozen_bad !== 0) begin errors++; $display("FAIL %s stalled output changed %0d times", name, frozen_bad); end
        checks++;
        if (first_bits !== exp_first) begin errors++; $display("FAIL %s first bits got %b want %b", name, first_bits, exp_first); end
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (cnt_ones[i] !== vals[i]) begin
                errors++;
                $display("FAIL %s lane %0d ones got %0d want %0d", name, i, cnt_ones[i], vals[i]);
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; in_val = '0; out_ready = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || out_bits !== 8'h00 || out_last !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset outputs got v=%b b=%h l=%b r=%b want 0 00 0 1", out_valid, out_bits, out_last, in_ready);
        end
        @(negedge clk);
    endtask

    task automatic test_counts();
        vals = '{0, 1, 2, 4, 7, 8, 14, 15};
        load_set();
        collect(1'b0);
        check_stream("counts");
        #1;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL counts_end got v=%b r=%b want 0 1", out_valid, in_ready);
        end
        @(negedge clk);
    endtask

    task automatic test_random_sets();
        for (int n = 0; n < 3; n++) begin
            random_vals();
            load_set();
            collect(1'b0);
            check_stream("random");
        end
    endtask

    task automatic test_back_to_back();
        int second [8];
        vals = '{3, 15, 0, 9, 6, 12, 1, 10};
        load_set();
        for (int i = 0; i < 8; i++) second[i] = $urandom_range(0, 15);
        in_valid = 1'b1;
        for (int i = 0; i < 8; i++) in_val[i*W +: W] = 4'(second[i]);
        collect(1'b0);
        check_stream("b2b_first");
        vals = second;
        collect(1'b0);
        check_stream("b2b_second");
        #1;
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL b2b_end out_valid got %b want 0", out_valid); end
        @(negedge clk);
    endtask

    task automatic test_backpressure();
        for (int n = 0; n < 2; n++) begin
            random_vals();
            load_set();
            collect(1'b1);
            check_stream("backpressure");
        end
    endtask

    task automatic test_reset_mid();
        random_vals();
        load_set();
        out_ready = 1'b1;
        repeat (7) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_bits !== 8'h00) begin
            errors++;
            $display("FAIL reset_mid got v=%b r=%b b=%h want 0 1 00", out_valid, in_ready, out_bits);
        end
        @(negedge clk);
        random_vals();
        load_set();
        collect(1'b0);
        check_stream("reset_restart");
    endtask

    task automatic test_correlation();
        vals = '{5, 5, 5, 5, 5, 5, 5, 5};
        load_set();
        collect(1'b0);
        check_stream("corr");
        checks++;
`ifdef SNG_LANE_ROTATE_EN
        if (diff_cycles == 0) begin errors++; $display("FAIL corr lanes differing cycles got 0 want >0"); end
`else
        if (diff_cycles != 0) begin errors++; $display("FAIL corr lanes differing cycles got %0d want 0", diff_cycles); end
`endif
    endtask

    initial begin
        test_reset();
        test_counts();
        test_random_sets();
        test_back_to_back();
        test_backpressure();
        test_reset_mid();
        test_correlation();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
